// File: rtl/mem_stage_ctrl_pkg.sv
// Shared defines for the memory stage: op codes, FSM states and
// write-back constants, plus small op-decode helpers.
package mem_stage_ctrl_pkg;

  // Memory op codes carried on the shared AluOp bus.
  localparam logic [7:0] ME_NOP_OP = 8'h00;
  localparam logic [7:0] EX_LB_OP  = 8'h20;
  localparam logic [7:0] EX_LH_OP  = 8'h21;
  localparam logic [7:0] EX_LW_OP  = 8'h23;
  localparam logic [7:0] EX_LBU_OP = 8'h24;
  localparam logic [7:0] EX_LHU_OP = 8'h25;
  localparam logic [7:0] EX_SB_OP  = 8'h28;
  localparam logic [7:0] EX_SH_OP  = 8'h29;
  localparam logic [7:0] EX_SW_OP  = 8'h2B;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic        WriteDisable = 1'b0;

  // Number of byte beats an op needs; 0 marks a non-memory op.
  function automatic logic [2:0] op_nbytes(input logic [7:0] op);
    case (op)
      EX_LB_OP, EX_LBU_OP, EX_SB_OP: op_nbytes = 3'd1;
      EX_LH_OP, EX_LHU_OP, EX_SH_OP: op_nbytes = 3'd2;
      EX_LW_OP, EX_SW_OP:            op_nbytes = 3'd4;
      default:                       op_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    op_is_store = (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_ext.sv
// Combinational load extension: turns the assembled little-endian word
// into the sign- or zero-extended write-back value for the load op.
module mem_load_ext
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] asm_i,
  input  logic [7:0]  op_i,
  output logic [31:0] ext_o
);

  // Select extension by op; word loads pass the assembly unchanged.
  always_comb begin
    case (op_i)
      EX_LB_OP:  ext_o = {{24{asm_i[7]}}, asm_i[7:0]};
      EX_LBU_OP: ext_o = {24'h0, asm_i[7:0]};
      EX_LH_OP:  ext_o = {{16{asm_i[15]}}, asm_i[15:0]};
      EX_LHU_OP: ext_o = {16'h0, asm_i[15:0]};
      default:   ext_o = asm_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: serialises loads/stores onto a byte-wide req/ack
// port, stalls upstream while busy, passes non-memory ops through.
// Optional macro MEM_MISALIGN_CHK_EN rejects misaligned halfword/word
// accesses and adds the misalign_o port.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int OP_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       aluop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic                  w_enable_i,
  input  logic [REG_ADDR_W-1:0] w_addr_i,
  input  logic [31:0]           w_data_i,
  output logic                  w_enable_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic [31:0]           w_data_o,
  output logic                  stall_req_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ack_i
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic                  misalign_o
`endif
);

  ms_state_e   state_q;
  logic [1:0]  cnt_q;
  logic [31:0] asm_q;

  logic [7:0]  op;
  logic [2:0]  nbytes;
  logic        is_mem;
  logic        is_store;
  logic [1:0]  last_cnt;
  logic [31:0] ld_ext;
  logic        misal;

  assign op       = 8'(aluop_i);
  assign nbytes   = op_nbytes(op);
  assign is_mem   = (nbytes != 3'd0);
  assign is_store = op_is_store(op);
  assign last_cnt = 2'(nbytes - 3'd1);

`ifdef MEM_MISALIGN_CHK_EN
  assign misal = ((nbytes == 3'd2) && mem_addr_i[0]) ||
                 ((nbytes == 3'd4) && (mem_addr_i[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  mem_load_ext u_ext (
    .asm_i (asm_q),
    .op_i  (op),
    .ext_o (ld_ext)
  );

  // Access FSM: beat counter and load assembly; upstream is frozen by
  // stall_req_o, so the op/address/data inputs stay put across BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= ZeroWord;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (is_mem && !misal) begin
            state_q <= MS_BUSY;
            cnt_q   <= 2'd0;
            asm_q   <= ZeroWord;
          end
        end
        MS_BUSY: begin
          if (mem_ack_i) begin
            if (!is_store) asm_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == last_cnt) state_q <= MS_DONE;
          end
        end
        MS_DONE: state_q <= MS_IDLE;
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is applied.
  always_comb begin
    w_enable_o  = WriteDisable;
    w_addr_o    = '0;
    w_data_o    = ZeroWord;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h0;
`ifdef MEM_MISALIGN_CHK_EN
    misalign_o  = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        MS_IDLE: begin
          if (!is_mem) begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = w_data_i;
          end else if (misal) begin
            w_addr_o   = w_addr_i;
            w_data_o   = w_data_i;
`ifdef MEM_MISALIGN_CHK_EN
            misalign_o = 1'b1;
`endif
          end else begin
            stall_req_o = 1'b1;
          end
        end
        MS_BUSY: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = is_store;
          mem_addr_o  = mem_addr_i + ADDR_W'(cnt_q);
          mem_wdata_o = w_data_i[{cnt_q, 3'b000} +: 8];
        end
        MS_DONE: begin
          if (!is_store) begin
            w_enable_o = w_enable_i;
            w_addr_o   = w_addr_i;
            w_data_o   = ld_ext;
          end
        end
        default: ;
      endcase
      // Writes to x0 are squashed entirely.
      if (w_enable_i && (w_addr_i == '0)) begin
        w_enable_o = WriteDisable;
        w_addr_o   = '0;
        w_data_o   = ZeroWord;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, wait states,
// reset mid-access, pass-through and x0 squash.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic        w_enable_i;
  logic [4:0]  w_addr_i;
  logic [31:0] w_data_i;
  logic        w_enable_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        stall_req_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .w_enable_i(w_enable_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  int total = 0, passed = 0, fails = 0;
  logic [31:0] baddr [4];
  logic [7:0]  bwd   [4];
  logic        bwe   [4];
  int          stalls, nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
    aluop_i = op; mem_addr_i = a; w_enable_i = we; w_addr_i = wa; w_data_i = wd;
  endtask

  // Called at a negedge with the op applied; returns at the DONE cycle
  // (sampled, before its posedge). Acks every (waitc+1)th request cycle.
  task automatic run(input int waitc, input logic [31:0] rword);
    int w = 0;
    bit done = 0;
    logic [31:0] pa = '0;
    logic [7:0]  pd = '0;
    stalls = 0; nb = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (c > 0 && !stall_req_o) done = 1;
      else begin
        if (stall_req_o) stalls++;
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
          if (w > 0) begin
            chk("hold_addr", mem_addr_o, pa);
            chk("hold_wdata", {24'h0, mem_wdata_o}, {24'h0, pd});
          end
          pa = mem_addr_o; pd = mem_wdata_o;
          if (w == waitc) begin
            mem_ack_i = 1'b1;
            if (nb < 4) begin
              mem_rdata_i = rword[8*nb +: 8];
              baddr[nb] = mem_addr_o; bwd[nb] = mem_wdata_o; bwe[nb] = mem_we_o;
            end
            nb++; w = 0;
          end else w++;
        end
        @(negedge clk);
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_next();
    mem_ack_i = 1'b0;
    set_in(ME_NOP_OP, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 8'h0;
    set_in(8'h01, 32'h0, 1'b1, 5'd3, 32'h5);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wen", w_enable_o, 0);
    chk("rst_wdata", w_data_o, 0);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_req", mem_req_o, 0);
    @(negedge clk); rst = 1'b0;

    // ADD pass-through
    #1;
    chk("add_wen", w_enable_o, 1);
    chk("add_waddr", w_addr_o, 3);
    chk("add_wdata", w_data_o, 32'h5);
    chk("add_stall", stall_req_o, 0);
    // x0 squash
    set_in(8'h01, 32'h0, 1'b1, 5'd0, 32'h55); #1;
    chk("x0_wen", w_enable_o, 0);
    chk("x0_wdata", w_data_o, 0);
    @(negedge clk);

    // LW 0x100
    set_in(EX_LW_OP, 32'h100, 1'b1, 5'd5, 32'h0);
    run(0, 32'h12345678);
    chk("lw_stalls", stalls, 5);
    chk("lw_beats", nb, 4);
    for (int k = 0; k < 4; k++) chk("lw_addr", baddr[k], 32'h100 + k);
    chk("lw_we", bwe[0], 0);
    chk("lw_data", w_data_o, 32'h12345678);
    chk("lw_wen", w_enable_o, 1);
    chk("lw_waddr", w_addr_o, 5);
    idle_next();
    #1; chk("lw_no_retrig", stall_req_o, 0);
    @(negedge clk);

    // LB / LBU at 0x203
    set_in(EX_LB_OP, 32'h203, 1'b1, 5'd6, 32'h0);
    run(0, 32'h00000080);
    chk("lb_stalls", stalls, 2);
    chk("lb_addr", baddr[0], 32'h203);
    chk("lb_data", w_data_o, 32'hFFFFFF80);
    idle_next();
    set_in(EX_LBU_OP, 32'h203, 1'b1, 5'd6, 32'h0);
    run(0, 32'h00000080);
    chk("lbu_data", w_data_o, 32'h00000080);
    idle_next();

    // LHU zero-extends a negative halfword
    set_in(EX_LHU_OP, 32'h10, 1'b1, 5'd7, 32'h0);
    run(0, 32'h00009234);
    chk("lhu_stalls", stalls, 3);
    chk("lhu_data", w_data_o, 32'h00009234);
    idle_next();

`ifndef MEM_MISALIGN_CHK_EN
    // LH sign-extends, address wraps past 2^32
    set_in(EX_LH_OP, 32'hFFFFFFFF, 1'b1, 5'd7, 32'h0);
    run(0, 32'h00009234);
    chk("lh_wrap_a0", baddr[0], 32'hFFFFFFFF);
    chk("lh_wrap_a1", baddr[1], 32'h0);
    chk("lh_data", w_data_o, 32'hFFFF9234);
    idle_next();

    // SH at 0x3FF
    set_in(EX_SH_OP, 32'h3FF, 1'b0, 5'd0, 32'hABCD1234);
    run(0, 32'h0);
    chk("sh_beats", nb, 2);
    chk("sh_a0", baddr[0], 32'h3FF);
    chk("sh_d0", bwd[0], 8'h34);
    chk("sh_a1", baddr[1], 32'h400);
    chk("sh_d1", bwd[1], 8'h12);
    chk("sh_we", bwe[1], 1);
    chk("sh_wen", w_enable_o, 0);
    idle_next();
`else
    // Misaligned LW is rejected in IDLE
    set_in(EX_LW_OP, 32'h102, 1'b1, 5'd5, 32'h0); #1;
    chk("mis_req", mem_req_o, 0);
    chk("mis_stall", stall_req_o, 0);
    chk("mis_pulse", misalign_o, 1);
    chk("mis_wen", w_enable_o, 0);
    @(negedge clk); #1;
    chk("mis_req2", mem_req_o, 0);
    idle_next(); #1;
    chk("mis_clear", misalign_o, 0);
`endif

    // SW with two wait cycles per beat
    set_in(EX_SW_OP, 32'h500, 1'b0, 5'd0, 32'hDEADBEEF);
    run(2, 32'h0);
    chk("sw_stalls", stalls, 13);
    chk("sw_beats", nb, 4);
    chk("sw_a3", baddr[3], 32'h503);
    chk("sw_d0", bwd[0], 8'hEF);
    chk("sw_d3", bwd[3], 8'hDE);
    chk("sw_wen", w_enable_o, 0);
    idle_next();

    // Reset after two acked beats of an LW
    set_in(EX_LW_OP, 32'h600, 1'b1, 5'd7, 32'h0);
    @(negedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 8'h11;
    @(negedge clk); #1;
    mem_rdata_i = 8'h22;
    @(negedge clk); #1;
    chk("rstm_busy", mem_req_o, 1);
    mem_ack_i = 1'b0; rst = 1'b1; #1;
    chk("rstm_req_in_rst", mem_req_o, 0);
    chk("rstm_wen_in_rst", w_enable_o, 0);
    @(negedge clk);
    rst = 1'b0; mem_ack_i = 1'b1;
    set_in(8'h01, 32'h0, 1'b1, 5'd3, 32'h5); #1;
    chk("rstm_req_after", mem_req_o, 0);
    chk("rstm_stall_after", stall_req_o, 0);
    chk("rstm_add_wdata", w_data_o, 32'h5);
    chk("rstm_add_waddr", w_addr_o, 3);
    @(negedge clk); #1;
    chk("rstm_late_ack", mem_req_o, 0);
    chk("rstm_add_wen", w_enable_o, 1);
    mem_ack_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's memory op code, effective address, write-back triple and store data.
- Serialises loads and stores onto a byte-wide request/acknowledge memory port, sign/zero-extends load data and stalls the pipeline while busy.
- Non-memory ops pass straight through to write-back with zero added latency.

Parameters:
- OP_W, 8, width of the op code bus (shared AluOp width).
- ADDR_W, 32, byte address width.
- REG_ADDR_W, 5, register file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- aluop_i  in  OP_W  memory op code from execute (ME_NOP_OP when not a memory op).
- mem_addr_i  in  ADDR_W  effective byte address.
- w_enable_i  in  1  register write enable.
- w_addr_i  in  REG_ADDR_W  destination register.
- w_data_i  in  32  ALU result, or store data for stores.
- w_enable_o  out  1  write-back enable.
- w_addr_o  out  REG_ADDR_W  write-back register.
- w_data_o  out  32  write-back data.
- stall_req_o  out  1  freeze upstream pipeline registers.
- mem_req_o  out  1  byte transaction request.
- mem_we_o  out  1  1 = write byte, 0 = read byte.
- mem_addr_o  out  ADDR_W  byte address of the current beat.
- mem_wdata_o  out  8  store byte.
- mem_rdata_i  in  8  load byte, valid when mem_ack_i = 1.
- mem_ack_i  in  1  beat complete.

Behaviour:
- Byte counts: LB/LBU/SB = 1, LH/LHU/SH = 2, LW/SW = 4.
- Byte order: little-endian; beat k uses address mem_addr_i + k, wrapping modulo 2^ADDR_W, and w_data_i[8k+7:8k] for stores.
- FSM states: IDLE, BUSY, DONE. Byte counter cnt, 2 bits. 32-bit load assembly register.
- IDLE:
  - Non-memory op: outputs are combinational pass-through of w_enable_i, w_addr_i, w_data_i; stall_req_o = 0.
  - Memory op: stall_req_o = 1 combinationally, cnt <= 0, next state BUSY.
- BUSY:
  - stall_req_o = 1 and mem_req_o = 1.
  - mem_addr_o, mem_we_o and mem_wdata_o are held stable until mem_ack_i is sampled high.
  - On ack: load captures mem_rdata_i into byte cnt of the assembly register and cnt increments.
  - Ack on the last beat moves to DONE.
  - mem_ack_i while mem_req_o = 0 is ignored.
- DONE:
  - stall_req_o = 0.
  - Load: w_data_o = extended assembled value; w_enable_o/w_addr_o follow the inputs.
  - Store: w_enable_o = 0.
  - Next state IDLE unconditionally. Inputs still hold the same op in DONE and must not retrigger.
- Extension: LB and LH sign-extend from bit 7 / bit 15; LBU and LHU zero-extend.
- Register x0: w_enable_i = 1 with w_addr_i = 0 gives w_enable_o = 0, w_addr_o = 0, w_data_o = 0.
- Latency: an N-byte access with zero-wait ack asserts stall_req_o for N+1 cycles; the result is valid in the DONE cycle.
- Reset:
  - While rst = 1, all outputs are 0 and the FSM goes to IDLE with cnt = 0 and the assembly register cleared.
  - Reset mid-access abandons the access: mem_req_o is low the cycle after rst is sampled, partial data is discarded, and no write-back occurs.
  - A late ack after reset is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Defined:
  - Misalignment is LH/LHU/SH with addr[0] != 0, or LW/SW with addr[1:0] != 0.
  - Such an access issues no beats and stays in IDLE with stall_req_o = 0.
  - It forces w_enable_o = 0 and pulses extra output port misalign_o = 1 for that cycle; misalign_o resets to 0.
- Undefined: misaligned accesses complete byte-serially like aligned ones; the misalign_o port is absent.

Decomposition:
- Shared defines header holds:
  - Op code constants EX_LB_OP … EX_SW_OP and ME_NOP_OP.
  - State encodings MS_IDLE/MS_BUSY/MS_DONE.
  - ZeroWord and WriteDisable.
- One natural sub-module: mem_load_ext. It is combinational; it takes the assembly word and op and produces the sign/zero-extended result.

Test Plan:
- LW at 0x00000100, memory bytes 78 56 34 12, ack every cycle -> 4 beats at 0x100..0x103, stall_req_o high 5 cycles, DONE w_data_o = 0x12345678.
- LB at 0x203 with byte 0x80 -> w_data_o = 0xFFFFFF80. LBU at the same address -> w_data_o = 0x00000080.
- SH of w_data_i = 0xABCD1234 at 0x000003FF -> beats write 0x34 at 0x3FF and 0x12 at 0x400 with mem_we_o = 1, w_enable_o = 0 in DONE.
- SW with ack delayed 3 cycles per beat -> mem_addr_o/mem_wdata_o stable while waiting, stall_req_o high 13 cycles.
- Reset asserted after 2 acked beats of an LW -> mem_req_o = 0 next cycle, FSM IDLE, no write-back, following ADD passes through.
- ADD with w_data_i = 0x5, w_addr_i = 3 -> same-cycle pass-through, stall_req_o = 0. With MEM_MISALIGN_CHK_EN, LW at 0x102 -> no mem_req_o, misalign_o pulse, w_enable_o = 0.
